draw_scheduler: RTL and testbench

Sequences the shared VGA write port through one full board redraw of the card game. On a `go` request it first runs the card-background drawer, then visits the 3×3 symbol grid in row-major order. For each cell it starts the symbol drawer selected by a per-cell symbol id, placing it at that cell's origin. It muxes exactly one drawer's pixel stream onto the single `x/y/colour/writeEn` port feeding VGAdraw, and signals completion to the game FSM.

---
 rtl/draw_scheduler_if.sv | 52 +++++
 rtl/draw_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_scheduler_if.sv
// Bundle of the scheduler's control, drawer-handshake and VGA write-port
// signals. The scheduler is the master; the drawers, the game FSM and
// VGAdraw are seen through the slave modport.
interface draw_scheduler_if #(
  parameter int NUM_SYM = 3
);
  // Game FSM side
  logic                   go;
  logic [17:0]            cell_map;
  logic                   busy;
  logic                   frame_done;

  // Background drawer
  logic                   bg_start;
  logic                   bg_done;
  logic [7:0]             bg_x;
  logic [6:0]             bg_y;
  logic [2:0]             bg_colour;
  logic                   bg_we;

  // Symbol drawers, drawer i in slice i of each packed vector
  logic [NUM_SYM-1:0]     sym_start;
  logic [7:0]             sym_ox;
  logic [6:0]             sym_oy;
  logic [NUM_SYM-1:0]     sym_done;
  logic [8*NUM_SYM-1:0]   sym_x;
  logic [7*NUM_SYM-1:0]   sym_y;
  logic [3*NUM_SYM-1:0]   sym_colour;
  logic [NUM_SYM-1:0]     sym_we;

  // VGA write port
  logic [7:0]             x;
  logic [6:0]             y;
  logic [2:0]             colour;
  logic                   writeEn;

  modport master (
    input  go, cell_map,
    input  bg_done, bg_x, bg_y, bg_colour, bg_we,
    input  sym_done, sym_x, sym_y, sym_colour, sym_we,
    output busy, frame_done, bg_start, sym_start, sym_ox, sym_oy,
    output x, y, colour, writeEn
  );

  modport slave (
    output go, cell_map,
    output bg_done, bg_x, bg_y, bg_colour, bg_we,
    output sym_done, sym_x, sym_y, sym_colour, sym_we,
    input  busy, frame_done, bg_start, sym_start, sym_ox, sym_oy,
    input  x, y, colour, writeEn
  );
endinterface

// File: rtl/draw_scheduler.sv
// Board redraw sequencer: runs the background drawer, then walks the 3x3
// symbol grid row-major, starting the drawer named by each cell's id at
// the cell origin, and muxes the active drawer onto the VGA write port.
module draw_scheduler #(
  parameter int ORIGIN_X = 50,
  parameter int ORIGIN_Y = 30,
  parameter int PITCH    = 20,
  parameter int NUM_SYM  = 3
) (
  input  logic             clk,
  input  logic             reset,
  draw_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BG_START   = 3'd1,
    BG_WAIT    = 3'd2,
    CELL_CHECK = 3'd3,
    SYM_START  = 3'd4,
    SYM_WAIT   = 3'd5,
    DONE       = 3'd6
  } state_t;

  // Origins are accumulated modulo the port widths, which matches the
  // truncation of ORIGIN + index * PITCH without any multiply or divide.
  localparam logic [7:0]         ORG_X  = 8'(ORIGIN_X);
  localparam logic [6:0]         ORG_Y  = 7'(ORIGIN_Y);
  localparam logic [7:0]         STEP_X = 8'(PITCH);
  localparam logic [6:0]         STEP_Y = 7'(PITCH);
  localparam logic [NUM_SYM-1:0] ONE    = NUM_SYM'(1);

  // Sequencer state
  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;          // cell index 0..8
  logic [1:0]         col_q, col_d;      // k % 3, tracked alongside k
  logic [17:0]        snap_q, snap_d;    // cell_map captured at go
  logic [1:0]         id_q, id_d;        // drawer of the current cell

  // Registered outputs
  logic [7:0]         sym_ox_q, sym_ox_d;
  logic [6:0]         sym_oy_q, sym_oy_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               bg_start_q, bg_start_d;
  logic [NUM_SYM-1:0] sym_start_q, sym_start_d;
  logic [7:0]         x_q, x_d;
  logic [6:0]         y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               we_q, we_d;

  // Decoded helpers
  logic [1:0]         cell_id;
  logic               cell_drawn;
  logic               last_cell;
  logic [NUM_SYM-1:0] grant_mask;
  logic               grant_done;
  logic               advance;

  // Decode the current cell and the granted drawer's done flag.
  always_comb begin
    cell_id    = snap_q[{k_q, 1'b0} +: 2];
    cell_drawn = (int'(cell_id) < NUM_SYM);
    last_cell  = (k_q == 4'd8);
    grant_mask = ONE << id_q;
    grant_done = |(bus.sym_done & grant_mask);
  end

  // Next-state, cell walk and registered control outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    col_d    = col_q;
    snap_d   = snap_q;
    id_d     = id_q;
    sym_ox_d = sym_ox_q;
    sym_oy_d = sym_oy_q;
    advance  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          snap_d   = bus.cell_map;
          k_d      = 4'd0;
          col_d    = 2'd0;
          sym_ox_d = ORG_X;
          sym_oy_d = ORG_Y;
          state_d  = BG_START;
        end
      end
      BG_START: state_d = BG_WAIT;
      BG_WAIT: begin
        if (bus.bg_done) state_d = CELL_CHECK;
      end
      CELL_CHECK: begin
        if (cell_drawn) begin
          id_d    = cell_id;
          state_d = SYM_START;
        end else if (last_cell) begin
          state_d = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      SYM_START: state_d = SYM_WAIT;
      SYM_WAIT: begin
        // Done is only looked at here, so a done raised alongside the
        // start pulse is never seen.
        if (grant_done) begin
          if (last_cell) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = CELL_CHECK;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Step to the next cell: move right one pitch, or wrap to the next row.
    if (advance) begin
      k_d = k_q + 4'd1;
      if (col_q == 2'd2) begin
        col_d    = 2'd0;
        sym_ox_d = ORG_X;
        sym_oy_d = sym_oy_q + STEP_Y;
      end else begin
        col_d    = col_q + 2'd1;
        sym_ox_d = sym_ox_q + STEP_X;
      end
    end

    // Outputs follow the state being entered, so they are flop-driven.
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    bg_start_d   = (state_d == BG_START);
    sym_start_d  = (state_d == SYM_START) ? (ONE << id_d) : '0;
  end

  // Pixel mux: the granted stream is registered onto the VGA port.
  always_comb begin
    x_d      = 8'd0;
    y_d      = 7'd0;
    colour_d = 3'd0;
    we_d     = 1'b0;
    if (state_q == BG_WAIT) begin
      x_d      = bus.bg_x;
      y_d      = bus.bg_y;
      colour_d = bus.bg_colour;
      we_d     = bus.bg_we;
    end else if (state_q == SYM_WAIT) begin
      x_d      = 8'(bus.sym_x      >> (8 * int'(id_q)));
      y_d      = 7'(bus.sym_y      >> (7 * int'(id_q)));
      colour_d = 3'(bus.sym_colour >> (3 * int'(id_q)));
      we_d     = |(bus.sym_we & grant_mask);
    end
  end

  // State and output registers; reset aborts any redraw silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= 4'd0;
      col_q        <= 2'd0;
      snap_q       <= 18'd0;
      id_q         <= 2'd0;
      sym_ox_q     <= 8'd0;
      sym_oy_q     <= 7'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bg_start_q   <= 1'b0;
      sym_start_q  <= '0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      we_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q      <= state_d;
      k_q          <= k_d;
      col_q        <= col_d;
      snap_q       <= snap_d;
      id_q         <= id_d;
      sym_ox_q     <= sym_ox_d;
      sym_oy_q     <= sym_oy_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      bg_start_q   <= bg_start_d;
      sym_start_q  <= sym_start_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      we_q         <= we_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bg_start   = bg_start_q;
  assign bus.sym_start  = sym_start_q;
  assign bus.sym_ox     = sym_ox_q;
  assign bus.sym_oy     = sym_oy_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.writeEn    = we_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler. A schedule model derived from the latency
// rules (cycle of every start, grant window and done) drives the drawers
// and checks every output every cycle; literal expectations pin the model.
module tb_draw_scheduler;
  localparam int NS   = 3;
  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic reset;

  draw_scheduler_if #(.NUM_SYM(NS)) bus();

  draw_scheduler #(
    .ORIGIN_X(50), .ORIGIN_Y(30), .PITCH(20), .NUM_SYM(NS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- schedule model ----------------
  int         owner     [MAXC];   // 0 none, 1 background, 2+i drawer i
  bit         done_here [MAXC];
  logic [2:0] exp_start [MAXC];
  bit         org_valid [MAXC];
  int         exp_ox    [MAXC];
  int         exp_oy    [MAXC];
  int         frame_cyc;

  task automatic build(input logic [17:0] map, input int bgd, input int sd);
    int t;
    for (int c = 0; c < MAXC; c++) begin
      owner[c] = 0; done_here[c] = 0; exp_start[c] = '0;
      org_valid[c] = 0; exp_ox[c] = 0; exp_oy[c] = 0;
    end
    for (int c = 2; c <= 2 + bgd; c++) owner[c] = 1;
    done_here[2 + bgd] = 1;
    t = 3 + bgd;
    for (int k = 0; k < 9; k++) begin
      int id = int'(map[2*k +: 2]);
      if (id < NS) begin
        exp_start[t + 1] = 3'(1 << id);
        for (int c = t + 1; c <= t + 2 + sd; c++) begin
          org_valid[c] = 1;
          exp_ox[c] = 50 + (k % 3) * 20;
          exp_oy[c] = 30 + (k / 3) * 20;
        end
        for (int c = t + 2; c <= t + 2 + sd; c++) owner[c] = 2 + id;
        done_here[t + 2 + sd] = 1;
        t += 3 + sd;
      end else begin
        t += 1;
      end
    end
    frame_cyc = t;
  endtask

  // ---------------- run control and observations ----------------
  bit          run_active = 0;
  int          cyc;
  int          abort_at = -1;
  int          ovr_at = -1;
  int          glitch_lo = 1000;
  int          glitch_hi = 0;
  logic [17:0] run_map;

  logic [7:0]  rec_x  [MAXC];
  logic [6:0]  rec_y  [MAXC];
  logic [2:0]  rec_c  [MAXC];
  logic        rec_we [MAXC];

  int          fd_seen;
  int          bg_cnt;
  int          n_st;
  int          st_id [16];
  int          st_ox [16];
  int          st_oy [16];
  logic [7:0]  obs_x [MAXC];
  logic [6:0]  obs_y [MAXC];
  logic [2:0]  obs_c [MAXC];
  logic        obs_we[MAXC];

  task automatic compare_cycle(input int c);
    logic ew;
    check("busy", bus.busy, (c >= 1 && c <= frame_cyc));
    check("bg_start", bus.bg_start, (c == 1));
    check("frame_done", bus.frame_done, (c == frame_cyc));
    check("sym_start", bus.sym_start, exp_start[c]);
    if (org_valid[c]) begin
      check("sym_ox", bus.sym_ox, exp_ox[c]);
      check("sym_oy", bus.sym_oy, exp_oy[c]);
    end
    ew = (c > 0) ? rec_we[c-1] : 1'b0;
    check("writeEn", bus.writeEn, ew);
    if (ew) begin
      check("x", bus.x, rec_x[c-1]);
      check("y", bus.y, rec_y[c-1]);
      check("colour", bus.colour, rec_c[c-1]);
    end
    if (bus.frame_done === 1'b1) fd_seen = c;
    if (bus.bg_start === 1'b1) bg_cnt++;
    if (bus.sym_start !== 3'b000 && n_st < 16) begin
      st_id[n_st] = int'(bus.sym_start);
      st_ox[n_st] = int'(bus.sym_ox);
      st_oy[n_st] = int'(bus.sym_oy);
      n_st++;
    end
    obs_x[c] = bus.x; obs_y[c] = bus.y; obs_c[c] = bus.colour; obs_we[c] = bus.writeEn;
  endtask

  task automatic drive_cycle(input int c);
    int ow = owner[c];
    bit glitch = (c >= glitch_lo && c <= glitch_hi);
    logic [8*NS-1:0] sx;
    logic [7*NS-1:0] sy;
    logic [3*NS-1:0] sc;
    logic [NS-1:0]   swe, sdn;
    bus.go       = (c == 0) || glitch;
    bus.cell_map = glitch ? ~run_map : run_map;
    bus.bg_x      = 8'($urandom);
    bus.bg_y      = 7'($urandom);
    bus.bg_colour = 3'($urandom);
    bus.bg_we     = 1'($urandom_range(0, 1));
    bus.bg_done   = (ow == 1) ? done_here[c] : 1'b1;
    for (int i = 0; i < NS; i++) begin
      sx[8*i +: 8] = 8'($urandom);
      sy[7*i +: 7] = 7'($urandom);
      sc[3*i +: 3] = 3'($urandom);
      swe[i] = 1'($urandom_range(0, 1));
      sdn[i] = (ow == 2 + i) ? done_here[c] : 1'b1;
    end
    if (c == ovr_at) begin
      sx[15:8] = 8'd12; sy[13:7] = 7'd34; sc[5:3] = 3'd5; swe[1] = 1'b1;
      swe[0] = 1'b1; sdn[0] = 1'b1;
    end
    bus.sym_x = sx; bus.sym_y = sy; bus.sym_colour = sc;
    bus.sym_we = swe; bus.sym_done = sdn;
    if (ow == 1) begin
      rec_x[c] = bus.bg_x; rec_y[c] = bus.bg_y; rec_c[c] = bus.bg_colour; rec_we[c] = bus.bg_we;
    end else if (ow >= 2) begin
      rec_x[c] = sx[8*(ow-2) +: 8]; rec_y[c] = sy[7*(ow-2) +: 7];
      rec_c[c] = sc[3*(ow-2) +: 3]; rec_we[c] = swe[ow-2];
    end else begin
      rec_x[c] = '0; rec_y[c] = '0; rec_c[c] = '0; rec_we[c] = 1'b0;
    end
  endtask

  // The compare process: check this cycle's outputs, then drive its inputs.
  always @(negedge clk) begin
    if (run_active) begin
      compare_cycle(cyc);
      if (cyc == abort_at) begin
        run_active = 0;
      end else begin
        drive_cycle(cyc);
        if (cyc >= frame_cyc + 3) begin
          bus.go = 1'b0;
          run_active = 0;
        end
        cyc++;
      end
    end
  end

  task automatic run_test(input logic [17:0] map, input int bgd, input int sd);
    build(map, bgd, sd);
    run_map = map;
    cyc = 0; fd_seen = -1; bg_cnt = 0; n_st = 0;
    @(posedge clk); #1;
    run_active = 1;
    for (int i = 0; i < 400 && run_active; i++) @(posedge clk);
    if (run_active) begin
      check("run_timeout", 1, 0);
      run_active = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_bg_start"}, bus.bg_start, 0);
    check({tag, "_sym_start"}, bus.sym_start, 0);
    check({tag, "_sym_ox"}, bus.sym_ox, 0);
    check({tag, "_sym_oy"}, bus.sym_oy, 0);
    check({tag, "_xyc"}, {bus.x, bus.y, bus.colour}, 0);
    check({tag, "_writeEn"}, bus.writeEn, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.go = 1'b0; bus.cell_map = '0;
    bus.bg_done = 1'b0; bus.bg_x = '0; bus.bg_y = '0; bus.bg_colour = '0; bus.bg_we = 1'b0;
    bus.sym_done = '0; bus.sym_x = '0; bus.sym_y = '0; bus.sym_colour = '0; bus.sym_we = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Full board, instant dones.
    run_test(18'h00000, 0, 0);
    check("full_frame_cycle", fd_seen, 30);
    check("full_bg_count", bg_cnt, 1);
    check("full_starts", n_st, 9);
    check("full_first", {st_id[0], st_ox[0], st_oy[0]}, {32'd1, 32'd50, 32'd30});
    check("full_fourth", {st_id[3], st_ox[3], st_oy[3]}, {32'd1, 32'd50, 32'd50});
    check("full_last", {st_id[8], st_ox[8], st_oy[8]}, {32'd1, 32'd90, 32'd70});

    // Empty board.
    run_test(18'h3FFFF, 0, 0);
    check("empty_frame_cycle", fd_seen, 12);
    check("empty_bg_count", bg_cnt, 1);
    check("empty_starts", n_st, 0);

    // Mixed map, slow drawers, directed pixel while drawer 1 is granted.
    ovr_at = 7;
    run_test(18'h3FEFD, 2, 1);
    ovr_at = -1;
    check("mixed_frame_cycle", fd_seen, 20);
    check("mixed_starts", n_st, 2);
    check("mixed_first", {st_id[0], st_ox[0], st_oy[0]}, {32'd2, 32'd50, 32'd30});
    check("mixed_second", {st_id[1], st_ox[1], st_oy[1]}, {32'd4, 32'd70, 32'd50});
    check("mixed_pixel", {obs_x[8], obs_y[8], obs_c[8], obs_we[8]}, {8'd12, 7'd34, 3'd5, 1'b1});

    // go and a new cell_map mid-redraw are ignored.
    glitch_lo = 8; glitch_hi = 10;
    run_test(18'h00000, 0, 0);
    glitch_lo = 1000; glitch_hi = 0;
    check("glitch_frame_cycle", fd_seen, 30);
    check("glitch_starts", n_st, 9);
    check("glitch_second", {st_ox[1], st_oy[1]}, {32'd70, 32'd30});

    // Reset while in SYM_WAIT aborts the redraw without frame_done.
    abort_at = 6;
    run_test(18'h00000, 0, 2);
    abort_at = -1;
    #2 reset = 1'b1;
    bus.go = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_frame_done", bus.frame_done, 0);
      check("abort_idle", bus.busy, 0);
    end
    run_test(18'h00000, 0, 0);
    check("restart_frame_cycle", fd_seen, 30);
    check("restart_bg_count", bg_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
